// File: rtl/operand_sequencer.sv
// Operand entry and handshake sequencer: collects two 12-bit operands as hex
// digits, launches a downstream core, captures its result and flags timeouts.
module operand_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  Nib,
  input  logic        NibValid,
  input  logic        Go,
  input  logic        CoreIdle,
  input  logic        CoreDone,
  input  logic [11:0] CoreA,
  output logic [11:0] Ain,
  output logic [11:0] Bin,
  output logic        Start,
  output logic        Ack,
  output logic [11:0] Result,
  output logic        ResultValid,
  output logic        Busy,
  output logic        Error
);

  typedef enum logic [7:0] {
    LOAD_A = 8'b0000_0001,
    LOAD_B = 8'b0000_0010,
    READY  = 8'b0000_0100,
    START  = 8'b0000_1000,
    WAIT   = 8'b0001_0000,
    ACK    = 8'b0010_0000,
    SHOW   = 8'b0100_0000,
    ERR    = 8'b1000_0000
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] digit;
  logic [7:0] wait_cnt;
  logic       loading;
  logic       limit_hit;

  assign loading   = (state == LOAD_A) || (state == LOAD_B);
  assign limit_hit = (wait_cnt == 8'(TIMEOUT - 1));
  assign Busy      = (state == START) || (state == WAIT) || (state == ACK);

  always_comb begin
    next_state = state;
    case (state)
      LOAD_A: if (NibValid && digit == 2'd2) next_state = LOAD_B;
      LOAD_B: if (NibValid && digit == 2'd2) next_state = READY;
      READY:  if (Go) next_state = START;
      START:  if (CoreIdle) next_state = WAIT;
      // A done arriving on the limit cycle is still accepted
      WAIT: begin
        if (CoreDone)       next_state = ACK;
        else if (limit_hit) next_state = ERR;
      end
      ACK:    next_state = SHOW;
      SHOW:   if (Go) next_state = LOAD_A;
      ERR:    next_state = ERR;
      default: next_state = LOAD_A;
    endcase
  end

  // Registered strobes/flags are derived from the upcoming state so they
  // line up exactly with state occupancy.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= LOAD_A;
      Ain         <= '0;
      Bin         <= '0;
      Result      <= '0;
      Start       <= 1'b0;
      Ack         <= 1'b0;
      ResultValid <= 1'b0;
      Error       <= 1'b0;
      digit       <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= next_state;
      Start       <= (next_state == START);
      Ack         <= (next_state == ACK);
      ResultValid <= (next_state == SHOW);
      Error       <= (next_state == ERR);

      if (NibValid && loading) begin
        digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
        if (state == LOAD_A) Ain <= {Ain[7:0], Nib};
        else                 Bin <= {Bin[7:0], Nib};
      end

      if (state == WAIT) begin
        if (CoreDone) begin
          Result   <= CoreA;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else begin
        wait_cnt <= '0;
      end

      if (state == SHOW && Go) begin
        Ain <= '0;
        Bin <= '0;
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer with a small behavioural core whose
// result is min(A,B) with the LSB cleared.
module tb_operand_sequencer;
  localparam int TO = 20;

  logic        Clk = 1'b0;
  logic        Reset, NibValid, Go;
  logic [3:0]  Nib;
  logic        CoreIdle, CoreDone;
  logic [11:0] CoreA;
  logic [11:0] Ain, Bin, Result;
  logic        Start, Ack, ResultValid, Busy, Error;

  int checks = 0;
  int fails  = 0;
  int s_cnt, a_cnt;

  logic force_idle_low = 1'b0;
  logic stuck_done     = 1'b0;

  operand_sequencer #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Nib(Nib), .NibValid(NibValid), .Go(Go),
    .CoreIdle(CoreIdle), .CoreDone(CoreDone), .CoreA(CoreA),
    .Ain(Ain), .Bin(Bin), .Start(Start), .Ack(Ack), .Result(Result),
    .ResultValid(ResultValid), .Busy(Busy), .Error(Error)
  );

  always #5 Clk = ~Clk;

  // Behavioural core: idle -> busy (3 cycles) -> done until acknowledged
  logic [1:0]  cphase;
  logic [1:0]  ccnt;
  logic [11:0] ca, cb, core_a;

  function automatic logic [11:0] core_fn(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] m;
    m = (a < b) ? a : b;
    return m & 12'hFFE;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      cphase <= 2'd0;
      ccnt   <= 2'd0;
      core_a <= 12'd0;
    end else begin
      case (cphase)
        2'd0: if (Start && CoreIdle) begin
          cphase <= 2'd1; ccnt <= 2'd2; ca <= Ain; cb <= Bin;
        end
        2'd1: if (ccnt == 2'd0) begin
          cphase <= 2'd2; core_a <= core_fn(ca, cb);
        end else ccnt <= ccnt - 2'd1;
        default: if (Ack) cphase <= 2'd0;
      endcase
    end
  end

  assign CoreIdle = (cphase == 2'd0) && !force_idle_low;
  assign CoreDone = (cphase == 2'd2) && !stuck_done;
  assign CoreA    = core_a;

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nib(input logic [3:0] n);
    Nib = n; NibValid = 1'b1; tick(); NibValid = 1'b0;
  endtask

  task automatic go();
    Go = 1'b1; tick(); Go = 1'b0;
  endtask

  task automatic run_core(output int s, output int a);
    s = int'(Start); a = 0;
    for (int i = 0; i < 60 && !ResultValid; i++) begin
      tick();
      s += int'(Start);
      a += int'(Ack);
    end
  endtask

  initial begin
    Reset = 1'b1; Nib = 4'h0; NibValid = 1'b0; Go = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    chk("rst_data",  {20'd0, Ain} | {20'd0, Bin} | {20'd0, Result}, 32'd0);
    chk("rst_flags", {27'd0, Start, Ack, ResultValid, Error, Busy}, 32'd0);
    chk("rst_state", 32'(dut.state), 32'h01);

    // Basic transaction 0x032 / 0x01F
    nib(4'h0); nib(4'h3); nib(4'h2);
    chk("ain_032", 32'(Ain), 32'h032);
    chk("st_loadb", 32'(dut.state), 32'h02);
    nib(4'h0); nib(4'h1); nib(4'hF);
    chk("bin_01f", 32'(Bin), 32'h01F);
    chk("st_ready", 32'(dut.state), 32'h04);
    go();
    chk("start_busy", {30'd0, Start, Busy}, 32'h3);
    run_core(s_cnt, a_cnt);
    chk("t1_starts", 32'(s_cnt), 32'd1);
    chk("t1_acks", 32'(a_cnt), 32'd1);
    chk("t1_result", 32'(Result), 32'h01E);
    chk("t1_rv", {30'd0, ResultValid, Busy}, 32'h2);
    chk("t1_st_show", 32'(dut.state), 32'h40);
    chk("t1_ops_stable", {8'd0, Ain, Bin}, {8'd0, 12'h032, 12'h01F});

    // Second transaction 0x100 / 0x100 then restart from SHOW
    go();
    chk("t1_restart", {8'd0, Ain, Bin}, 32'd0);
    nib(4'h1); nib(4'h0); nib(4'h0);
    nib(4'h1); nib(4'h0); nib(4'h0);
    go();
    run_core(s_cnt, a_cnt);
    chk("t2_result", 32'(Result), 32'h100);
    chk("t2_rv_err", {30'd0, ResultValid, Error}, 32'h2);
    go();
    chk("t2_st_loada", 32'(dut.state), 32'h01);
    chk("t2_cleared", {7'd0, Ain, Bin, ResultValid}, 32'd0);
    chk("t2_result_kept", 32'(Result), 32'h100);

    // Go ignored while loading; Go+NibValid in READY acts as Go only
    nib(4'h1); nib(4'h2); nib(4'h3);
    nib(4'h4);
    go();
    chk("t3_go_ignored", {23'd0, Start, dut.state}, 32'h02);
    nib(4'h5); nib(4'h6);
    chk("t3_bin", 32'(Bin), 32'h456);
    Nib = 4'hA; NibValid = 1'b1; Go = 1'b1;
    tick();
    NibValid = 1'b0; Go = 1'b0;
    chk("t3_st_start", 32'(dut.state), 32'h08);
    chk("t3_ops", {8'd0, Ain, Bin}, {8'd0, 12'h123, 12'h456});
    run_core(s_cnt, a_cnt);
    chk("t3_result", 32'(Result), 32'h122);
    go();

    // Core stalls in idle, then never completes
    nib(4'h0); nib(4'h0); nib(4'h5);
    nib(4'h0); nib(4'h0); nib(4'h7);
    force_idle_low = 1'b1;
    go();
    s_cnt = int'(Start);
    repeat (5) begin tick(); s_cnt += int'(Start); end
    force_idle_low = 1'b0;
    stuck_done = 1'b1;
    tick();
    chk("t4_start_cycles", 32'(s_cnt), 32'd6);
    chk("t4_st_wait", {23'd0, Start, dut.state}, 32'h10);
    a_cnt = 0;
    repeat (TO - 1) begin tick(); a_cnt += int'(Ack); end
    chk("t4_pre_timeout", {23'd0, Error, dut.state}, 32'h10);
    tick();
    chk("t4_error", {29'd0, Error, Busy, Start}, 32'h4);
    chk("t4_no_ack", 32'(a_cnt) + 32'(Ack), 32'd0);
    Go = 1'b1; Nib = 4'h9; NibValid = 1'b1;
    tick();
    Go = 1'b0; NibValid = 1'b0;
    chk("t4_err_sticky", {23'd0, Error, dut.state}, 32'h180);
    chk("t4_ain_frozen", 32'(Ain), 32'h005);

    // Reset in the middle of WAIT, with competing inputs
    Reset = 1'b1; tick(); Reset = 1'b0;
    stuck_done = 1'b1;
    nib(4'h0); nib(4'h0); nib(4'hA);
    nib(4'h0); nib(4'h0); nib(4'hB);
    go();
    tick(); tick(); tick();
    chk("t5_st_wait", {23'd0, Busy, dut.state}, 32'h110);
    Reset = 1'b1; Go = 1'b1; Nib = 4'hF; NibValid = 1'b1;
    tick();
    Reset = 1'b0; Go = 1'b0; NibValid = 1'b0;
    stuck_done = 1'b0;
    chk("t5_rst_data", {20'd0, Ain} | {20'd0, Bin} | {20'd0, Result}, 32'd0);
    chk("t5_rst_flags", {27'd0, Start, Ack, ResultValid, Error, Busy}, 32'd0);
    chk("t5_rst_state", 32'(dut.state), 32'h01);
    nib(4'hA); nib(4'hB); nib(4'hC);
    chk("t5_ain", 32'(Ain), 32'hABC);

    // Done arriving on the very edge the timeout would fire
    nib(4'hD); nib(4'hE); nib(4'hF);
    stuck_done = 1'b1;
    go();
    tick();
    repeat (TO - 1) tick();
    chk("t6_still_wait", {23'd0, Error, dut.state}, 32'h10);
    stuck_done = 1'b0;
    tick();
    chk("t6_done_wins", {22'd0, Ack, Error, dut.state}, 32'h220);
    chk("t6_result", 32'(Result), 32'hABC);
    tick();
    chk("t6_show", {30'd0, ResultValid, Ack}, 32'h2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum WAIT cycles before error; range 1..255.
REQ-002 Clk  in  1  rising-edge clock; single clock domain.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 Nib  in  4  hex digit being entered.
REQ-005 NibValid  in  1  one-cycle strobe; Nib valid this cycle.
REQ-006 Go  in  1  one-cycle strobe; launch computation, or start new entry from SHOW.
REQ-007 CoreIdle  in  1  downstream core is in its initial state.
REQ-008 CoreDone  in  1  downstream core is in its done state.
REQ-009 CoreA  in  12  downstream core result.
REQ-010 Ain  out  12  operand A to core.
REQ-011 Bin  out  12  operand B to core.
REQ-012 Start  out  1  start request to core.
REQ-013 Ack  out  1  done acknowledge to core.
REQ-014 Result  out  12  captured core result.
REQ-015 ResultValid  out  1  Result holds a valid completed value.
REQ-016 Busy  out  1  high in START, WAIT and ACK.
REQ-017 Error  out  1  core timeout; sticky until Reset.

Function
REQ-018 The block SHALL implement these one-hot states: LOAD_A, LOAD_B, READY, START, WAIT, ACK, SHOW, ERR.
REQ-019 In LOAD_A and LOAD_B, each NibValid SHALL shift Nib in MSB-first (Ain <= {Ain[7:0],Nib}, Bin likewise) and increment a 2-bit digit count.
REQ-020 On the third NibValid (count==2), the count SHALL clear and the state SHALL advance: LOAD_A->LOAD_B and LOAD_B->READY.
REQ-021 Go in LOAD_A and LOAD_B SHALL be ignored; NibValid outside LOAD_A and LOAD_B SHALL be ignored.
REQ-022 In READY, Go SHALL move the state to START; Go together with NibValid SHALL act as Go only, leaving Ain/Bin unchanged.
REQ-023 Start SHALL be high exactly while in START; START->WAIT on the first edge where CoreIdle=1; Start held indefinitely while CoreIdle=0.
REQ-024 Ain/Bin SHALL remain stable from READY through SHOW.
REQ-025 WAIT SHALL count cycles from 0.
  - CoreDone=1: Result <= CoreA, state -> ACK, count clears.
  - Count reaches TIMEOUT with CoreDone=0: state -> ERR.
  - CoreDone=1 on the same edge as the timeout limit: done wins.
REQ-026 Ack SHALL be high for exactly one cycle, while in ACK; ACK->SHOW unconditionally.
REQ-027 In SHOW, ResultValid=1. Go SHALL:
  - clear Ain, Bin and ResultValid (Result retained);
  - move the state to LOAD_A.
REQ-028 In ERR, Error=1, Start=Ack=0, and all inputs SHALL be ignored; only Reset exits.
REQ-029 Busy SHALL be a combinational decode of the state; all other outputs SHALL be registered.

Reset
REQ-030 On Reset=1 at a rising edge, from any state, the block SHALL set:
  - state=LOAD_A;
  - Ain=Bin=Result=0;
  - Start=Ack=ResultValid=Error=0;
  - digit and timeout counts = 0.
REQ-031 Reset SHALL take priority over every simultaneous input.

Verification
REQ-032 Nibs 0,3,2 then 0,1,F, Go, behavioural core model -> Ain=0x032, Bin=0x01F, one Start cycle, Result=0x01E, one-cycle Ack, ResultValid=1.
REQ-033 Operands 0x100/0x100 -> Result=0x100, no Error; then Go in SHOW -> LOAD_A, Ain=Bin=0, ResultValid=0, Result still 0x100.
REQ-034 Go pulsed during LOAD_B -> ignored; in READY, Go+NibValid(Nib=0xA) same cycle -> START, Ain/Bin unchanged.
REQ-035 Stub CoreIdle=0 for 5 cycles -> Start high 5+1 cycles; then CoreDone stuck 0 -> Error=1 after TIMEOUT WAIT cycles, Ack never asserted, Go ignored.
REQ-036 Reset asserted mid-WAIT -> next cycle all outputs zero, Busy=0, state LOAD_A; three nibbles then load Ain correctly.
